// File: rtl/acc_serial_tx.sv
// Serial transmitter for the accumulator register bank read side.
// Ports: clk, rst_n, d/load/ready capture handshake, tx line, busy, done.
module acc_serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] d,
    input  logic              load,
    output logic              ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [BW-1:0]     bitcnt, bitcnt_n;
    logic [CW-1:0]     baud, baud_n;
    logic              par, par_n;
    logic              tx_n, ready_n, busy_n, done_n;
    logic              adv;

    assign adv = (baud == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            baud   <= '0;
            par    <= 1'b0;
            tx     <= 1'b1;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            shreg  <= shreg_n;
            bitcnt <= bitcnt_n;
            baud   <= baud_n;
            par    <= par_n;
            tx     <= tx_n;
            ready  <= ready_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

    // Next-state logic; outputs are derived from the next state so that
    // they can be registered without a cycle of lag.
    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        bitcnt_n = bitcnt;
        baud_n   = baud;
        par_n    = par;
        done_n   = 1'b0;

        if (state != IDLE) begin
            baud_n = adv ? '0 : baud + CW'(1);
        end

        unique case (state)
            IDLE: begin
                if (load && ready) begin
                    shreg_n  = d;
                    par_n    = ^d;
                    bitcnt_n = '0;
                    baud_n   = '0;
                    state_n  = START;
                end
            end
            START: begin
                if (adv) state_n = DATA;
            end
            DATA: begin
                if (adv) begin
                    shreg_n = shreg >> 1;
                    if (bitcnt == BIT_LAST) begin
                        bitcnt_n = '0;
                        state_n  = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bitcnt_n = bitcnt + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (adv) state_n = STOP;
            end
            STOP: begin
                if (adv) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        tx_n = 1'b1;
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
            PARITY:  tx_n = par_n;
            default: tx_n = 1'b1;
        endcase
        ready_n = (state_n == IDLE);
        busy_n  = ~ready_n;
    end

endmodule

// File: tb/tb_acc_serial_tx.sv
// Scoreboard bench for acc_serial_tx across three configurations.
// Lanes: 0 = 4 clk/bit no parity, 1 = 4 clk/bit parity, 2 = 1 clk/bit.
module tb_acc_serial_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load [3];
    logic [7:0] d [3];
    logic       tx [3];
    logic       ready [3];
    logic       busy [3];
    logic       done [3];

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int free_at [3];

    logic [3:0] q0 [$];
    logic [3:0] q1 [$];
    logic [3:0] q2 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    acc_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u0 (
        .clk(clk), .rst_n(rst_n), .d(d[0]), .load(load[0]),
        .ready(ready[0]), .tx(tx[0]), .busy(busy[0]), .done(done[0]));
    acc_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u1 (
        .clk(clk), .rst_n(rst_n), .d(d[1]), .load(load[1]),
        .ready(ready[1]), .tx(tx[1]), .busy(busy[1]), .done(done[1]));
    acc_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) u2 (
        .clk(clk), .rst_n(rst_n), .d(d[2]), .load(load[2]),
        .ready(ready[2]), .tx(tx[2]), .busy(busy[2]), .done(done[2]));

    function automatic int cpb(int lane);
        return (lane == 2) ? 1 : 4;
    endfunction

    function automatic bit pe(int lane);
        return lane == 1;
    endfunction

    task automatic qpush(int lane, logic [3:0] e);
        case (lane)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(int lane);
        case (lane)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Reference: the frame as a list of line levels, each held cpb cycles,
    // then one idle cycle carrying done. Entries are {tx,ready,busy,done}.
    task automatic push_frame(int lane, logic [7:0] v);
        logic bits [$];
        int ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            bits.push_back(v[i]);
            ones += int'(v[i]);
        end
        if (pe(lane)) bits.push_back(1'(ones % 2));
        bits.push_back(1'b1);
        foreach (bits[k])
            for (int c = 0; c < cpb(lane); c++)
                qpush(lane, {bits[k], 3'b010});
        qpush(lane, 4'b1101);
        free_at[lane] = cyc + bits.size() * cpb(lane) + 1;
    endtask

    task automatic check(string name, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc %0d tx/ready/busy/done got %b want %b",
                     name, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] outs(int lane);
        return {tx[lane], ready[lane], busy[lane], done[lane]};
    endfunction

    task automatic mon(int lane);
        logic [3:0] e;
        e = 4'b1100;
        case (lane)
            0: if (q0.size() != 0) e = q0.pop_front();
            1: if (q1.size() != 0) e = q1.pop_front();
            default: if (q2.size() != 0) e = q2.pop_front();
        endcase
        check($sformatf("lane%0d", lane), outs(lane), e);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0);
            mon(1);
            mon(2);
        end
    end

    // Drive load for one cycle; if wait_free, hold off until the model
    // says the transmitter can accept a word.
    task automatic send(int lane, logic [7:0] v, bit wait_free);
        @(posedge clk);
        #1;
        if (wait_free)
            while (cyc < free_at[lane]) begin
                @(posedge clk);
                #1;
            end
        load[lane] = 1'b1;
        d[lane] = v;
        @(posedge clk);
        if (cyc >= free_at[lane]) push_frame(lane, v);
        #1;
        load[lane] = 1'b0;
        d[lane] = 8'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            load[i] = 1'b0;
            d[i] = 8'h00;
            free_at[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("reset%0d", i), outs(i), 4'b1100);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);

        send(0, 8'hA5, 1);
        send(1, 8'h07, 1);
        send(1, 8'h03, 1);
        send(2, 8'hC3, 1);

        send(0, 8'h3C, 1);
        repeat (8) @(posedge clk);
        send(0, 8'hFF, 0);
        send(0, 8'h81, 1);

        send(0, 8'h55, 1);
        repeat (17) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", outs(0), 4'b1100);
        q0.delete();
        q1.delete();
        q2.delete();
        for (int i = 0; i < 3; i++) free_at[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(0, 8'h0F, 1);

        for (int i = 0; i < 9; i++)
            send(i % 3, 8'($urandom), 1);
        for (int i = 0; i < 4; i++)
            send(2, 8'($urandom), 1);

        repeat (60) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (qsize(i) != 0) begin
                fails++;
                $display("FAIL drain%0d left %0d want 0", i, qsize(i));
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/acc_serial_tx.md
Name: acc_serial_tx

Overview:
- Serial transmitter at the read side of the accumulator's 8-bit register bank.
- Captures a parallel word from the accumulator output on a valid/ready handshake.
- Sends the word as a UART-style frame on a single line: start bit, data LSB-first, optional even parity, stop bit.
- Lets the accumulated result leave the chip over one pin.

Parameters:
- DATA_W, 8, data bits per frame; must be at least 1.
- CLKS_PER_BIT, 4, clock cycles per serial bit; must be at least 1.
- PARITY_EN, 0, 1 inserts an even-parity bit after the data; 0 omits it.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- d  input  DATA_W  parallel word from the accumulator register.
- load  input  1  request to capture d; qualified by ready.
- ready  output  1  high when the block can accept a word.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is in flight.
- done  output  1  one-cycle pulse marking frame completion.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. All outputs are registered.
- Reset values: tx=1, ready=1, busy=0, done=0. The state machine is IDLE, and the shift register, bit counter and baud counter are 0.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1, ready=1, busy=0.
- Capture: a rising edge with load=1 and ready=1 is the capture edge. At that edge d is latched into the shift register, parity is computed (XOR of all d bits), and the state goes to START. From the next cycle tx=0, ready=0, busy=1.
- load while ready=0 is ignored. d is don't-care outside the capture edge.
- Bit timing: each state holds tx for exactly CLKS_PER_BIT cycles. A baud counter runs 0..CLKS_PER_BIT-1; the state or bit advances on the edge where the counter equals CLKS_PER_BIT-1.
- DATA: tx = shift_reg[0]. Shift right once per bit. Exactly DATA_W bits are sent, LSB first, then the state goes to PARITY if PARITY_EN=1, else STOP.
- PARITY: tx = XOR of the captured word (even parity: the total count of ones over data plus parity is even).
- STOP: tx=1 for CLKS_PER_BIT cycles.
- End of STOP: at the final STOP edge the state goes to IDLE, with ready=1, busy=0 and done=1 for exactly one cycle.
- Frame length: N = (DATA_W + 2 + PARITY_EN) * CLKS_PER_BIT cycles, counted from the cycle after the capture edge. done is high in cycle N+1 after the capture edge.
- Back-to-back frames: load=1 in the done cycle is accepted. The next start bit begins the following cycle, so there is no idle gap and tx goes directly from stop (1) to start (0).
- CLKS_PER_BIT=1: one cycle per bit, with no extra cycles between states.
- Reset mid-frame: asserting rst_n low forces tx=1, ready=1, busy=0 and done=0 immediately, without waiting for clk. The partial frame is discarded. After release, the block waits in IDLE for a new load.
- Invariants:
  - busy is always the complement of ready.
  - done is never high while busy=1.
  - tx is never X after reset.

Test Plan:
- Reset and idle: hold rst_n=0 for 3 cycles, then release with load=0 for 20 cycles -> tx=1, ready=1, busy=0 and done=0 throughout.
- Basic frame (CLKS_PER_BIT=4, PARITY_EN=0): load d=8'hA5 -> tx holds 0,1,0,1,0,0,1,0,1,1 with 4 cycles per bit (40 cycles total); ready=0 for those 40 cycles; done pulses once in cycle 41 after the capture edge.
- Parity (PARITY_EN=1, CLKS_PER_BIT=4): d=8'h07 -> parity bit 1 and a 44-cycle frame; d=8'h03 -> parity bit 0.
- Busy and back-to-back: load 8'h3C, pulse load with d=8'hFF at cycle 10 -> ignored, and the frame carries 8'h3C. Then assert load with d=8'h81 in the done cycle -> start bit in the next cycle, 8'h81 sent, and no idle-high cycle between the frames.
- Reset mid-frame: pull rst_n low during data bit 3 of 8'h55 -> tx=1, ready=1, busy=0 before the next clk edge. After release, load 8'h0F -> a clean, correct frame.
- Minimum rate (CLKS_PER_BIT=1): d=8'hC3 -> a 10-cycle frame 0,1,1,0,0,0,0,1,1,1, with done in cycle 11.
